array_index_feeder: RTL and testbench

//  Upstream feeder for the byte-array stage. Buffers incoming bytes in a DEPTH-entry FIFO.

---
 rtl/array_index_feeder.sv | 92 +++++++++
 tb/tb_array_index_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_index_feeder.sv
// Byte FIFO feeding the byte-array stage with (value, index) pairs over valid/ready.
// The index counts accepted output transfers and wraps from IDX_MAX back to 0.
module array_index_feeder #(
    parameter int DEPTH   = 8,
    parameter int IDX_MAX = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_array_val,
    output logic signed [31:0] out_index,
    output logic [4:0]         count
);

    localparam int                 PTR_W     = $clog2(DEPTH);
    localparam logic [4:0]         DEPTH_C   = 5'(DEPTH);
    localparam logic signed [31:0] IDX_MAX_C = 32'(IDX_MAX);

    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]         count_q, count_d;
    logic signed [31:0] index_q, index_d;
    logic               push, pop;

    function automatic logic signed [31:0] next_index(input logic signed [31:0] idx);
        return (idx == IDX_MAX_C) ? 32'sd0 : idx + 32'sd1;
    endfunction

    assign in_ready      = (count_q != DEPTH_C);
    assign out_valid     = (count_q != 5'd0);
    assign out_array_val = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign out_index     = index_q;
    assign count         = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        index_d  = index_q;
        if (flush) begin
            // flush discards everything, including any transfer offered this cycle
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 5'd0;
            index_d  = 32'sd0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                index_d  = next_index(index_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            index_q  <= 32'sd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            index_q  <= index_d;
        end
    end

    // storage is not reset; only the write enable is gated by rst/flush
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_array_index_feeder.sv
// Directed self-checking bench for array_index_feeder (default params plus an IDX_MAX=2 copy).
module tb_array_index_feeder;

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               out_ready;
    logic               in_ready, out_valid;
    logic [7:0]         out_array_val;
    logic signed [31:0] out_index;
    logic [4:0]         count;
    logic               in_ready_b, out_valid_b;
    logic [7:0]         out_array_val_b;
    logic signed [31:0] out_index_b;
    logic [4:0]         count_b;

    int tests = 0;
    int fails = 0;

    array_index_feeder #(.DEPTH(8), .IDX_MAX(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_array_val(out_array_val), .out_index(out_index), .count(count)
    );

    array_index_feeder #(.DEPTH(8), .IDX_MAX(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_array_val(out_array_val_b), .out_index(out_index_b), .count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        tests++;
        if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++;
        if (out_index !== 32'sd0) begin fails++; $display("FAIL reset_out_index got %0d want 0", out_index); end
        tests++;
        if (out_array_val !== 8'h00) begin fails++; $display("FAIL reset_out_array_val got %h want 00", out_array_val); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tests++;
        if (count !== 5'd8) begin fails++; $display("FAIL fill_count got %0d want 8", count); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %0b want 0", in_ready); end
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        tests++;
        if (count !== 5'd8) begin fails++; $display("FAIL full_drop_count got %0d want 8", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_array_val !== 8'h10 + 8'(i) || out_index !== 32'(i)) begin
                fails++;
                $display("FAIL drain_pair%0d got v=%0b (%h,%0d) want v=1 (%h,%0d)",
                         i, out_valid, out_array_val, out_index, 8'h10 + 8'(i), i);
            end
            tick();
        end
        out_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL drain_empty got count=%0d v=%0b want 0 0", count, out_valid);
        end
        tests++;
        if (out_index !== 32'sd0) begin fails++; $display("FAIL drain_index_wrap got %0d want 0", out_index); end
    endtask

    task automatic test_index_wrap();
        int k;
        do_reset();
        k = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_data  = 8'h40 + 8'(c);
            if (out_valid) begin
                tests++;
                if (out_array_val !== 8'h40 + 8'(k) || out_index !== 32'(k % 8)) begin
                    fails++;
                    $display("FAIL wrap_a%0d got (%h,%0d) want (%h,%0d)",
                             k, out_array_val, out_index, 8'h40 + 8'(k), k % 8);
                end
                tests++;
                if (out_valid_b !== 1'b1 || out_index_b !== 32'(k % 3)) begin
                    fails++;
                    $display("FAIL wrap_b%0d got v=%0b idx=%0d want v=1 idx=%0d",
                             k, out_valid_b, out_index_b, k % 3);
                end
                k++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (k != 10) begin fails++; $display("FAIL wrap_pop_count got %0d want 10", k); end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp [4];
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'hA5;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h01 + 8'(i);
            tick();
        end
        tests++;
        if (count !== 5'd3) begin fails++; $display("FAIL simul_pre_count got %0d want 3", count); end
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        tests++;
        if (out_array_val !== exp[0] || out_index !== 32'sd0) begin
            fails++; $display("FAIL simul_pop0 got (%h,%0d) want (01,0)", out_array_val, out_index);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (count !== 5'd3) begin fails++; $display("FAIL simul_count got %0d want 3", count); end
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_array_val !== exp[i] || out_index !== 32'(i)) begin
                fails++;
                $display("FAIL simul_pop%0d got v=%0b (%h,%0d) want (%h,%0d)",
                         i, out_valid, out_array_val, out_index, exp[i], i);
            end
            tick();
        end
        out_ready = 1'b0;
        tests++;
        if (count !== 5'd0) begin fails++; $display("FAIL simul_final_count got %0d want 0", count); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        tests++;
        if (out_index !== 32'sd2 || count !== 5'd3 || out_array_val !== 8'h52) begin
            fails++;
            $display("FAIL flush_pre got idx=%0d count=%0d val=%h want 2 3 52", out_index, count, out_array_val);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (count !== 5'd0 || out_valid !== 1'b0 || out_index !== 32'sd0 || out_array_val !== 8'h00) begin
            fails++;
            $display("FAIL flush_clear got count=%0d v=%0b idx=%0d val=%h want 0 0 0 00",
                     count, out_valid, out_index, out_array_val);
        end
        tick();
        tests++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_no_capture got count=%0d v=%0b want 0 0", count, out_valid);
        end
        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_array_val !== 8'h77 || out_index !== 32'sd0) begin
            fails++;
            $display("FAIL flush_restart got v=%0b (%h,%0d) want 1 (77,0)", out_valid, out_array_val, out_index);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]         q [$];
        int                 sent, recv, cycles;
        int                 exp_idx;
        logic               hold;
        logic [7:0]         hold_val;
        logic signed [31:0] hold_idx;
        do_reset();
        sent = 0; recv = 0; cycles = 0; exp_idx = 0; hold = 1'b0;
        hold_val = 8'h00; hold_idx = 32'sd0;
        while (recv < 200 && cycles < 5000) begin
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            if (hold) begin
                tests++;
                if (out_valid !== 1'b1 || out_array_val !== hold_val || out_index !== hold_idx) begin
                    fails++;
                    $display("FAIL bp_stable got v=%0b (%h,%0d) want (%h,%0d)",
                             out_valid, out_array_val, out_index, hold_val, hold_idx);
                end
            end
            tests++;
            if (count !== 5'(q.size())) begin
                fails++; $display("FAIL bp_count got %0d want %0d", count, q.size());
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0 || out_array_val !== q[0] || out_index !== 32'(exp_idx)) begin
                    fails++;
                    $display("FAIL bp_pop%0d got (%h,%0d) want (%h,%0d)",
                             recv, out_array_val, out_index, (q.size() != 0) ? q[0] : 8'hxx, exp_idx);
                end
                if (q.size() != 0) void'(q.pop_front());
                exp_idx = (exp_idx == 7) ? 0 : exp_idx + 1;
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                sent++;
            end
            hold     = out_valid && !out_ready;
            hold_val = out_array_val;
            hold_idx = out_index;
            tick();
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests++;
        if (recv != 200) begin fails++; $display("FAIL bp_timeout got %0d pops want 200", recv); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_index_wrap();
        test_simul_push_pop();
        test_flush();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
